// File: rtl/class_vote_argmax.sv
// class_vote_argmax
//   Collects per-clause votes into saturating signed class sums, then scans the
//   classes to find the highest sum. On a tie the lowest class index wins.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   img_rst           per-image clear of the sums, the counter and the FSM
//   clause_done       a clause result is presented this cycle
//   clause_op         clause output (the vote)
//   class_no          class that owns the result
//   clause_no         clause index; even adds the vote, odd subtracts it
//   clauses           clauses per class, held stable for the image
//   sum_rd_addr/data  combinational debug read of one class sum
//   pred_class        registered winning class
//   pred_valid        one-cycle pulse when pred_class is updated
//   busy              high while scanning
//   late_err          sticky: result arrived outside ACCUM or had a bad class_no
//
// state | meaning
// ACCUM | accept votes into the class sums
// SCAN  | walk classes 0..CLASSN-1 tracking the running maximum
// HOLD  | prediction published; sums frozen until img_rst
module class_vote_argmax #(
  parameter int CLAUSEN = 10,
  parameter int CLASSN  = 5,
  parameter int T       = 4,
  parameter int SUM_W   = $clog2(CLAUSEN) + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       img_rst,
  input  logic                       clause_done,
  input  logic                       clause_op,
  input  logic [$clog2(CLASSN)-1:0]  class_no,
  input  logic [$clog2(CLAUSEN):0]   clause_no,
  input  logic [$clog2(CLAUSEN):0]   clauses,
  input  logic [$clog2(CLASSN)-1:0]  sum_rd_addr,
  output logic signed [SUM_W-1:0]    sum_rd_data,
  output logic [$clog2(CLASSN)-1:0]  pred_class,
  output logic                       pred_valid,
  output logic                       busy,
  output logic                       late_err
);

  localparam int CLS_W = $clog2(CLASSN);
  localparam int CLN_W = $clog2(CLAUSEN) + 1;
  localparam int CNT_W = $clog2(CLASSN * CLAUSEN + 1);
  // wide enough for CLASSN * clauses at any value of the clauses port
  localparam int TGT_W = CLS_W + 1 + CLN_W;

  localparam logic [CLS_W:0]          CLASSN_L = (CLS_W + 1)'(CLASSN);
  localparam logic [CLS_W-1:0]        LAST_IDX = CLS_W'(CLASSN - 1);
  localparam logic signed [SUM_W-1:0] T_POS    = SUM_W'(T);
  localparam logic signed [SUM_W-1:0] T_NEG    = -SUM_W'(T);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic signed [SUM_W-1:0]   sums [CLASSN];
  logic [CNT_W-1:0]          cnt;
  logic [CLS_W-1:0]          scan_idx;
  logic signed [SUM_W-1:0]   best_sum;
  logic [CLS_W-1:0]          best_idx;

  logic                      in_range;
  logic                      accept;
  logic                      bad_result;
  logic                      last_hit;
  logic [TGT_W-1:0]          target;
  logic [TGT_W-1:0]          cnt_plus;
  logic signed [SUM_W-1:0]   acc_cur;
  logic signed [SUM_W-1:0]   acc_new;
  logic signed [SUM_W-1:0]   scan_cur;
  logic                      scan_take;
  logic                      scan_last;
  logic [CLS_W-1:0]          win_idx;
  logic signed [SUM_W-1:0]   win_sum;

  // result acceptance and vote saturation
  always_comb begin
    in_range   = ({1'b0, class_no} < CLASSN_L);
    accept     = (state == ACCUM) && clause_done && !img_rst && in_range;
    bad_result = clause_done && !img_rst && ((state != ACCUM) || !in_range);
    target     = TGT_W'(CLASSN) * TGT_W'(clauses);
    cnt_plus   = TGT_W'(cnt) + TGT_W'(1);
    // clauses == 0 gives target 0, which cnt_plus can never equal
    last_hit   = accept && (cnt_plus == target);

    acc_cur = '0;
    if (in_range) acc_cur = sums[class_no];
    acc_new = acc_cur;
    if (clause_op) begin
      if (!clause_no[0] && (acc_cur != T_POS)) acc_new = acc_cur + SUM_W'(1);
      if (clause_no[0] && (acc_cur != T_NEG))  acc_new = acc_cur - SUM_W'(1);
    end
  end

  // scan comparator; index 0 seeds the running maximum
  always_comb begin
    scan_cur  = sums[scan_idx];
    scan_take = (scan_idx == '0) || (scan_cur > best_sum);
    scan_last = (scan_idx == LAST_IDX);
    win_idx   = scan_take ? scan_idx : best_idx;
    win_sum   = scan_take ? scan_cur : best_sum;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (last_hit) state_nxt = SCAN;
      SCAN:    if (scan_last) state_nxt = HOLD;
      HOLD:    state_nxt = HOLD;
      default: state_nxt = ACCUM;
    endcase
    if (img_rst) state_nxt = ACCUM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      cnt        <= '0;
      scan_idx   <= '0;
      best_sum   <= '0;
      best_idx   <= '0;
      pred_class <= '0;
      pred_valid <= 1'b0;
      late_err   <= 1'b0;
      for (int i = 0; i < CLASSN; i++) sums[i] <= '0;
    end else begin
      state      <= state_nxt;
      pred_valid <= 1'b0;
      if (img_rst) begin
        cnt      <= '0;
        scan_idx <= '0;
        for (int i = 0; i < CLASSN; i++) sums[i] <= '0;
      end else begin
        if (accept) begin
          sums[class_no] <= acc_new;
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
        end
        if (bad_result) late_err <= 1'b1;
        if (state == SCAN) begin
          best_sum <= win_sum;
          best_idx <= win_idx;
          if (scan_last) begin
            scan_idx   <= '0;
            pred_class <= win_idx;
            pred_valid <= 1'b1;
          end else begin
            scan_idx <= scan_idx + CLS_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    sum_rd_data = '0;
    if ({1'b0, sum_rd_addr} < CLASSN_L) sum_rd_data = sums[sum_rd_addr];
  end

  assign busy = (state == SCAN);

endmodule

// File: tb/tb_class_vote_argmax.sv
// Self-checking bench for class_vote_argmax with default parameters
// (CLAUSEN=10, CLASSN=5, T=4). Expected predictions and their cycle of
// arrival go into a scoreboard queue; a negedge monitor pops on pred_valid.
module tb_class_vote_argmax;

  logic              clk = 1'b0;
  logic              rst;
  logic              img_rst;
  logic              clause_done;
  logic              clause_op;
  logic [2:0]        class_no;
  logic [4:0]        clause_no;
  logic [4:0]        clauses;
  logic [2:0]        sum_rd_addr;
  logic signed [5:0] sum_rd_data;
  logic [2:0]        pred_class;
  logic              pred_valid;
  logic              busy;
  logic              late_err;

  class_vote_argmax dut (
    .clk         (clk),
    .rst         (rst),
    .img_rst     (img_rst),
    .clause_done (clause_done),
    .clause_op   (clause_op),
    .class_no    (class_no),
    .clause_no   (clause_no),
    .clauses     (clauses),
    .sum_rd_addr (sum_rd_addr),
    .sum_rd_data (sum_rd_data),
    .pred_class  (pred_class),
    .pred_valid  (pred_valid),
    .busy        (busy),
    .late_err    (late_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    int cls;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   last_cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // monitor: every pred_valid pulse must match a queued expectation
  always @(negedge clk) begin
    if (pred_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_pred_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pred_class", int'(pred_class), e.cls);
        check("pred_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vote(input int cls, input int cln, input bit op);
    class_no    = cls[2:0];
    clause_no   = cln[4:0];
    clause_op   = op;
    clause_done = 1'b1;
    last_cyc    = cyc;
    tick();
    clause_done = 1'b0;
    clause_op   = 1'b0;
  endtask

  // one image with clauses=2: ops[2c] is clause 0 of class c, ops[2c+1] clause 1
  task automatic send_image(input bit [9:0] ops);
    for (int c = 0; c < 5; c++)
      for (int k = 0; k < 2; k++)
        vote(c, k, ops[2 * c + k]);
  endtask

  task automatic expect_pred(input int cls);
    exp_t e;
    e.cls = cls;
    e.cyc = last_cyc + 6;
    sb.push_back(e);
  endtask

  task automatic check_sum(input int idx, input int exp);
    sum_rd_addr = idx[2:0];
    #1;
    check($sformatf("sum[%0d]", idx), int'(sum_rd_data), exp);
  endtask

  task automatic check_sums(input int s0, input int s1, input int s2,
                            input int s3, input int s4);
    check_sum(0, s0);
    check_sum(1, s1);
    check_sum(2, s2);
    check_sum(3, s3);
    check_sum(4, s4);
  endtask

  task automatic do_img_rst();
    img_rst = 1'b1;
    tick();
    img_rst = 1'b0;
  endtask

  bit [9:0] ops;

  initial begin
    rst = 1'b1; img_rst = 1'b0; clause_done = 1'b0; clause_op = 1'b0;
    class_no = '0; clause_no = '0; clauses = 5'd2; sum_rd_addr = '0;
    ticks(2);
    rst = 1'b0;

    // reset state
    check("rst_pred_class", int'(pred_class), 0);
    check("rst_pred_valid", int'(pred_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_late_err", int'(late_err), 0);
    check_sums(0, 0, 0, 0, 0);

    // class 2 gets (1,0), others (0,1) -> sums {-1,-1,+1,-1,-1}, winner 2
    ops = 10'b10_10_01_10_10;
    send_image(ops);
    expect_pred(2);
    check("scan_busy", int'(busy), 1);
    ticks(8);
    check("hold_busy", int'(busy), 0);
    check_sums(-1, -1, 1, -1, -1);

    // result in HOLD: ignored, flags late_err, no second pulse
    vote(0, 0, 1'b1);
    ticks(8);
    check("hold_late_err", int'(late_err), 1);
    check_sums(-1, -1, 1, -1, -1);
    check("hold_pred_class", int'(pred_class), 2);
    do_img_rst();
    check_sums(0, 0, 0, 0, 0);
    check("img_rst_late_err_kept", int'(late_err), 1);
    check("img_rst_pred_kept", int'(pred_class), 2);

    // saturation at +T and -T; FSM back in ACCUM since votes are accepted
    clauses = 5'd10;
    do_img_rst();
    for (int i = 0; i < 6; i++) begin
      vote(0, (2 * i) % 10, 1'b1);
      check_sum(0, (i < 4) ? i + 1 : 4);
    end
    for (int i = 0; i < 6; i++) begin
      vote(1, (2 * i + 1) % 10, 1'b1);
      check_sum(1, (i < 4) ? -(i + 1) : -4);
    end
    check("sat_busy", int'(busy), 0);

    // clauses=0 never leaves ACCUM
    clauses = 5'd0;
    do_img_rst();
    for (int i = 0; i < 12; i++) begin
      vote(i % 5, i % 2, 1'b0);
      check("clauses0_busy", int'(busy), 0);
    end
    ticks(3);
    check("clauses0_busy_after", int'(busy), 0);

    // img_rst wins over a simultaneous result; counter stays 0, so the
    // following tie image must take exactly 10 results to reach SCAN
    clauses = 5'd2;
    do_img_rst();
    img_rst = 1'b1;
    vote(0, 0, 1'b1);
    img_rst = 1'b0;
    check_sums(0, 0, 0, 0, 0);
    ops = 10'b00_01_00_01_00;
    send_image(ops);
    expect_pred(1);
    ticks(8);
    check_sums(0, 1, 0, 1, 0);

    // rst clears late_err; then an out-of-range class sets it
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_late_err", int'(late_err), 0);
    check("rst2_pred_class", int'(pred_class), 0);
    vote(5, 0, 1'b1);
    check("oob_late_err", int'(late_err), 1);
    check_sums(0, 0, 0, 0, 0);
    // redo the tie to get pred_class=1 before the aborted scan
    send_image(ops);
    expect_pred(1);
    ticks(8);
    check("tie_pred_class", int'(pred_class), 1);
    do_img_rst();

    // rst during the 3rd SCAN cycle aborts with no pulse
    ops = 10'b01_00_00_00_00;
    send_image(ops);
    tick();
    tick();
    check("scan3_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_pred_valid", int'(pred_valid), 0);
    check("abort_pred_class", int'(pred_class), 0);
    check("abort_late_err", int'(late_err), 0);
    ticks(10);
    check("abort_busy_later", int'(busy), 0);

    check("sb_pending", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
